m_clock_set_ctrl: RTL and testbench

//  Sequences manual time-setting of the sec/min/hr counter chain.

---
 rtl/m_clock_set_ctrl.sv | 176 +++++++++++++++++
 tb/tb_m_clock_set_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m_clock_set_ctrl.sv
// rtl/m_clock_set_ctrl.sv - manual time-set sequencer: button debounce, field select, press/auto-repeat pulses
module m_clock_set_ctrl #(
    parameter int DEB_TICKS  = 3,
    parameter int LONG_TICKS = 10,
    parameter int REP_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode,
    input  logic       set_sec,
    input  logic       set_min,
    input  logic       set_hr,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    output logic       stop,
    output logic       up_sec,
    output logic       dn_sec,
    output logic       up_min,
    output logic       dn_min,
    output logic       up_hr,
    output logic       dn_hr,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_WAIT   = 3'd1,
        S_PRESS  = 3'd2,
        S_REPEAT = 3'd3,
        S_LOCK   = 3'd4
    } state_t;

    localparam int DW = $clog2(DEB_TICKS + 1);

    // bit 0 = up, bit 1 = down; 1 means pressed
    logic [1:0]    raw;
    logic [1:0]    lvl;
    logic [DW-1:0] deb_cnt [2];

    assign raw = {~btn_dn_n, ~btn_up_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl        <= 2'b00;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
                    lvl[i]     <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [2:0] fld;
    logic       press_any;
    logic       press_up;

    assign fld       = set_hr ? 3'b100 : set_min ? 3'b010 : set_sec ? 3'b001 : 3'b000;
    assign press_any = lvl[0] ^ lvl[1];
    assign press_up  = lvl[0] & ~lvl[1];

    state_t     state, state_n;
    logic [7:0] hold_cnt, hold_n;
    logic [7:0] rep_cnt, rep_n;
    logic [2:0] lat_fld, lat_fld_n;
    logic       lat_up, lat_up_n;
    logic       emit;
    logic [2:0] emit_fld;
    logic       emit_up;
    logic [5:0] pulse, pulse_n;
    logic       bad_hold;

    // leaving a held press: both down, released, or direction/field changed
    assign bad_hold = (lvl == 2'b11) || (press_up != lat_up) || (fld != lat_fld);

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        rep_n     = rep_cnt;
        lat_fld_n = lat_fld;
        lat_up_n  = lat_up;
        emit      = 1'b0;
        emit_fld  = lat_fld;
        emit_up   = lat_up;
        if (!mode) begin
            state_n = S_RUN;
            hold_n  = '0;
            rep_n   = '0;
        end else if (tick) begin
            case (state)
                S_RUN: begin
                    state_n = S_WAIT;
                    hold_n  = '0;
                    rep_n   = '0;
                end
                S_WAIT: begin
                    if (press_any && fld != 3'b000) begin
                        state_n   = S_PRESS;
                        lat_fld_n = fld;
                        lat_up_n  = press_up;
                        hold_n    = '0;
                        emit      = 1'b1;
                        emit_fld  = fld;
                        emit_up   = press_up;
                    end
                end
                S_PRESS, S_REPEAT: begin
                    if (lvl == 2'b00) begin
                        state_n = S_WAIT;
                        hold_n  = '0;
                        rep_n   = '0;
                    end else if (bad_hold) begin
                        state_n = S_LOCK;
                        hold_n  = '0;
                        rep_n   = '0;
                    end else if (state == S_PRESS) begin
                        if (hold_cnt >= 8'(LONG_TICKS - 1)) begin
                            state_n = S_REPEAT;
                            hold_n  = 8'(LONG_TICKS);
                            rep_n   = '0;
                            emit    = 1'b1;
                        end else begin
                            hold_n = hold_cnt + 8'd1;
                        end
                    end else if (rep_cnt == 8'(REP_TICKS - 1)) begin
                        rep_n = '0;
                        emit  = 1'b1;
                    end else begin
                        rep_n = rep_cnt + 8'd1;
                    end
                end
                S_LOCK: begin
                    if (lvl == 2'b00) state_n = S_WAIT;
                end
                default: state_n = S_RUN;
            endcase
        end
        pulse_n = 6'b000000;
        if (emit) begin
            pulse_n = {emit_fld[2] & ~emit_up, emit_fld[2] & emit_up,
                       emit_fld[1] & ~emit_up, emit_fld[1] & emit_up,
                       emit_fld[0] & ~emit_up, emit_fld[0] & emit_up};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            lat_fld  <= 3'b000;
            lat_up   <= 1'b0;
            pulse    <= 6'b000000;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            rep_cnt  <= rep_n;
            lat_fld  <= lat_fld_n;
            lat_up   <= lat_up_n;
            pulse    <= pulse_n;
        end
    end

    assign stop      = (state != S_RUN);
    assign fsm_state = state;
    assign {dn_hr, up_hr, dn_min, up_min, dn_sec, up_sec} = pulse;

endmodule

// File: tb/tb_m_clock_set_ctrl.sv
// tb/tb_m_clock_set_ctrl.sv - directed bench for m_clock_set_ctrl
module tb_m_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, mode, set_sec, set_min, set_hr, btn_up_n, btn_dn_n;
    logic       stop, up_sec, dn_sec, up_min, dn_min, up_hr, dn_hr;
    logic [2:0] fsm_state;
    logic [5:0] pv;

    m_clock_set_ctrl #(.DEB_TICKS(3), .LONG_TICKS(10), .REP_TICKS(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode),
        .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr),
        .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n), .stop(stop),
        .up_sec(up_sec), .dn_sec(dn_sec), .up_min(up_min), .dn_min(dn_min),
        .up_hr(up_hr), .dn_hr(dn_hr), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // index: 0 up_sec, 1 dn_sec, 2 up_min, 3 dn_min, 4 up_hr, 5 dn_hr
    assign pv = {dn_hr, up_hr, dn_min, up_min, dn_sec, up_sec};

    int total = 0;
    int bad   = 0;
    int tick_no = 0;
    int stamp_q[$];
    int idx_q[$];
    int multi = 0;

    always @(negedge clk) begin
        if ($countones(pv) > 1) multi++;
        for (int i = 0; i < 6; i++) begin
            if (pv[i]) begin
                stamp_q.push_back(tick_no);
                idx_q.push_back(i);
            end
        end
    end

    typedef struct {
        logic [2:0] sw;
        logic       up;
        int         hold;
        int         exp_idx;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            tick_no++;
            @(negedge clk);
            tick = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    function automatic int cnt_idx(input int start, input int idx);
        int c = 0;
        for (int k = start; k < idx_q.size(); k++) if (idx_q[k] == idx) c++;
        return c;
    endfunction

    function automatic int cnt_all(input int start);
        return idx_q.size() - start;
    endfunction

    task automatic run_vec(input int n, input vec_t v);
        int qs, base;
        string tag;
        {set_hr, set_min, set_sec} = v.sw;
        qs   = idx_q.size();
        base = tick_no + 1;
        if (v.up) btn_up_n = 1'b0; else btn_dn_n = 1'b0;
        do_ticks(v.hold);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        do_ticks(6);
        tag = $sformatf("vec%0d", n);
        chk({tag, "_cnt"}, cnt_idx(qs, v.exp_idx), v.exp_cnt);
        chk({tag, "_other"}, cnt_all(qs) - cnt_idx(qs, v.exp_idx), 0);
        if (v.exp_cnt > 0) chk({tag, "_first"}, stamp_q[qs] - base, 3);
        chk({tag, "_state"}, int'(fsm_state), 1);
    endtask

    initial begin
        int qs, base;
        int exp_rep[6];
        vecs[0] = '{3'b010, 1'b1,  5, 2, 1};
        vecs[1] = '{3'b001, 1'b0, 30, 1, 6};
        vecs[2] = '{3'b101, 1'b1,  3, 4, 1};
        vecs[3] = '{3'b000, 1'b1,  5, 0, 0};
        vecs[4] = '{3'b010, 1'b0,  2, 3, 0};
        vecs[5] = '{3'b100, 1'b0, 10, 5, 1};
        vecs[6] = '{3'b100, 1'b0, 11, 5, 2};
        vecs[7] = '{3'b001, 1'b1, 14, 0, 2};
        vecs[8] = '{3'b010, 1'b1, 15, 2, 3};
        vecs[9] = '{3'b111, 1'b0,  5, 5, 1};
        exp_rep = '{3, 13, 17, 21, 25, 29};

        rst = 1'b1; tick = 1'b0; mode = 1'b0;
        set_sec = 1'b0; set_min = 1'b0; set_hr = 1'b0;
        btn_up_n = 1'b1; btn_dn_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stop", int'(stop), 0);
        chk("rst_state", int'(fsm_state), 0);
        chk("rst_pulses", int'(pv), 0);
        rst = 1'b0;

        qs = idx_q.size();
        do_ticks(20);
        chk("run_pulses", cnt_all(qs), 0);
        chk("run_stop", int'(stop), 0);
        chk("run_state", int'(fsm_state), 0);

        mode = 1'b1;
        do_ticks(1);
        chk("wait_state", int'(fsm_state), 1);
        chk("wait_stop", int'(stop), 1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // full auto-repeat cadence
        {set_hr, set_min, set_sec} = 3'b001;
        qs = idx_q.size(); base = tick_no + 1;
        btn_dn_n = 1'b0;
        do_ticks(30);
        btn_dn_n = 1'b1;
        do_ticks(6);
        chk("rep_cnt", cnt_idx(qs, 1), 6);
        for (int k = 0; k < 6; k++)
            if (qs + k < stamp_q.size())
                chk($sformatf("rep_at%0d", k), stamp_q[qs + k] - base, exp_rep[k]);

        // field change while held -> LOCK
        {set_hr, set_min, set_sec} = 3'b010;
        btn_up_n = 1'b0;
        do_ticks(5);
        {set_hr, set_min, set_sec} = 3'b001;
        do_ticks(1);
        chk("fld_lock", int'(fsm_state), 4);
        btn_up_n = 1'b1;
        do_ticks(4);
        chk("fld_unlock", int'(fsm_state), 1);

        // second button in REPEAT -> LOCK
        qs = idx_q.size();
        btn_up_n = 1'b0;
        do_ticks(15);
        btn_dn_n = 1'b0;
        do_ticks(4);
        chk("both_lock", int'(fsm_state), 4);
        chk("both_pre_cnt", cnt_idx(qs, 0), 3);
        qs = idx_q.size();
        do_ticks(5);
        btn_up_n = 1'b1;
        do_ticks(5);
        chk("lock_hold", int'(fsm_state), 4);
        btn_dn_n = 1'b1;
        do_ticks(4);
        chk("lock_release", int'(fsm_state), 1);
        chk("lock_pulses", cnt_all(qs), 0);

        // mode drop mid-REPEAT
        btn_up_n = 1'b0;
        do_ticks(15);
        chk("mode_rep", int'(fsm_state), 3);
        mode = 1'b0;
        @(posedge clk); #1;
        chk("mode_state", int'(fsm_state), 0);
        chk("mode_stop", int'(stop), 0);
        qs = idx_q.size();
        do_ticks(10);
        chk("mode_pulses", cnt_all(qs), 0);
        btn_up_n = 1'b1;
        do_ticks(4);
        mode = 1'b1;
        do_ticks(1);

        // async reset mid-REPEAT, then full debounce again
        btn_up_n = 1'b0;
        do_ticks(15);
        chk("rst_rep", int'(fsm_state), 3);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_state", int'(fsm_state), 0);
        chk("rstmid_stop", int'(stop), 0);
        @(negedge clk);
        rst = 1'b0;
        qs = idx_q.size(); base = tick_no + 1;
        do_ticks(5);
        chk("rst_repress_cnt", cnt_idx(qs, 0), 1);
        if (cnt_all(qs) > 0) chk("rst_repress_at", stamp_q[qs] - base, 3);
        btn_up_n = 1'b1;
        do_ticks(5);

        chk("onehot", multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
